mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the CPU datapath and the 32×512 synchronous RAM. Accepts single-word read/write requests through a req/done handshake, holds the address in MAR and the data in MDR, and drives the RAM's Read/Write strobes for exactly one cycle per access. It absorbs the RAM's one-cycle registered-read latency, so the datapath sees a registered, stable read word when `done` is asserted.

## Interface
- `ADDR_W`, 9: width of the address bus (512 words).
- `DATA_W`, 32: data word width.
- `DEPTH`, 512: number of populated words. Addresses at or above this value are rejected.

Ports. The block runs on one clock, `clk`. Reset `clr` is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  synchronous active-high reset.
- `req`  in  1  request strobe. Sampled only in IDLE.
- `wr`  in  1  1 = write, 0 = read. Sampled with `req`.
- `addr`  in  ADDR_W  word address. Sampled into MAR with `req`.
- `wdata`  in  DATA_W  write data. Sampled into MDR with `req` when `wr`=1.
- `rdata`  out  DATA_W  MDR contents. Valid while `done`=1 for a read; held until the next accepted request.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  high with `done` when the address was out of range.
- `ram_read`  out  1  to RAM Read.
- `ram_write`  out  1  to RAM Write.
- `ram_addr`  out  ADDR_W  to RAM address. Always equals MAR.
- `ram_din`  out  DATA_W  to RAM data_in. Always equals MDR.
- `ram_dout`  in  DATA_W  from RAM data_out. Valid the cycle after `ram_read` is sampled.

## Operation
- The FSM has four states: IDLE, ACCESS, CAPTURE, DONE. `ram_read`, `ram_write`, `done`, `busy` and `err` are decoded from state and a registered error flag only, with no combinational path from inputs.
- **IDLE.** If `req`=1:
  - Load MAR←`addr`, and MDR←`wdata` if `wr`=1. Latch `wr` into an op register.
  - If `addr` ≥ DEPTH, set the error flag and go to DONE. The RAM is not touched.
  - Otherwise clear the error flag and go to ACCESS.
- **ACCESS.** Assert `ram_read`=1 for a read or `ram_write`=1 for a write, never both.
  - Read: go to CAPTURE.
  - Write: go to DONE.
- **CAPTURE.** Load MDR←`ram_dout`, then go to DONE.
- **DONE.** `done`=1, with `err` equal to the error flag. Go to IDLE unconditionally.
- `req` outside IDLE is ignored; it is not queued. A request held high through DONE is accepted on the IDLE cycle that follows.
- Width rule: addresses are compared unsigned against DEPTH. With DEPTH=2^ADDR_W, `err` can never assert.

## Timing
- Reset: `clr`=1 at an edge forces IDLE, MAR=0, MDR=0, op=0, error flag=0. Outputs after that edge: `busy`=`done`=`err`=`ram_read`=`ram_write`=0, `rdata`=0, `ram_addr`=0, `ram_din`=0.
- Reset mid-operation aborts the access. A RAM strobe asserted in the same cycle as `clr` is still seen by the RAM at that edge; no strobe follows it.
- In the latencies below, edge *n* is the *n*-th rising edge after the edge that samples `req`.
- **Read:** `req` is sampled at edge 0.
  - Cycle 1: ACCESS, `ram_read`=1.
  - Cycle 2: CAPTURE. MDR loads at edge 2.
  - Cycle 3: `done`=1 and `rdata` is valid.
  - Request-to-done is 3 cycles; the next request can be accepted at edge 4.
- **Write:** cycle 1 is ACCESS with `ram_write`=1, and `done`=1 in cycle 2. The RAM holds the new word from edge 2.
- **Out-of-range:** `done`=`err`=1 in cycle 1 after acceptance. No strobe is issued.
- `busy` rises in the cycle after acceptance and falls in the cycle after DONE.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum (IDLE, ACCESS, CAPTURE, DONE);
  - the defaults for ADDR_W, DATA_W and DEPTH;
  - op encoding constants OP_READ=0 and OP_WRITE=1.
- One sub-module, `mdr_reg`: a DATA_W register with synchronous clear and a two-source load mux (`wdata` or `ram_dout`). It is instantiated once for MDR. MAR is a plain register in the top level.

## Test plan
- Reset, then write `addr`=0x005, `wdata`=0xDEADBEEF: `ram_write`=1 for exactly one cycle with `ram_addr`=0x005, and `done`=1 two cycles after `req`.
- Read back 0x005: `ram_read` pulses once, `done`=1 three cycles after `req`, `rdata`=0xDEADBEEF, `err`=0.
- With DEPTH=256, read at `addr`=0x100: `done`=`err`=1 one cycle after `req`, with no `ram_read` or `ram_write` pulse.
- Hold `req` high for 10 cycles during alternating read/write traffic: each transaction is accepted only in IDLE, with one `done` per accepted request. The strobes are never both high.
- Assert `clr` during CAPTURE of a read: the next cycle has all outputs 0 and the state is IDLE; the following request completes normally.
- Write 0x1FF←0xFFFFFFFF, then read 0x1FF, and read 0x000 after writing 0x12345678 there: the top-address and zero-address boundaries both return the data written.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory controller.
//   - state_e       : controller FSM states
//   - *_DEFAULT     : default parameter values for mem_ctrl
//   - OP_READ/WRITE : encoding of the latched operation bit
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 9;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned DEPTH_DEFAULT  = 512;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StDone
    } state_e;

endpackage

// File: rtl/mdr_reg.sv
// mdr_reg: memory data register.
// Ports:
//   clk, clr      - clock, synchronous active-high clear
//   load_wdata_i  - load q_o from wdata_i (takes priority)
//   load_rdata_i  - load q_o from ram_dout_i
//   wdata_i       - write data from the datapath
//   ram_dout_i    - read data from the RAM
//   q_o           - register contents
module mdr_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_wdata_i,
    input  logic              load_rdata_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_wdata_i) begin
            q_d = wdata_i;
        end else if (load_rdata_i) begin
            q_d = ram_dout_i;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-word read/write controller in front of a synchronous RAM
// with one-cycle registered read latency.
// Ports:
//   clk, clr           - clock, synchronous active-high reset
//   req, wr            - request strobe and direction (1 = write), sampled in idle
//   addr, wdata        - word address and write data, sampled with req
//   rdata              - MDR contents (read result while done=1)
//   busy, done, err    - status: not idle / completion pulse / out-of-range
//   ram_read/ram_write - one-cycle RAM strobes
//   ram_addr, ram_din  - MAR and MDR driven to the RAM
//   ram_dout           - RAM read data, valid the cycle after ram_read
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              op_q, op_d;
    logic              err_q, err_d;
    logic              accept;
    logic              addr_oor;
    logic [DATA_W-1:0] mdr;

    assign accept = (state_q == StIdle) && req;

    // When DEPTH covers the whole address space no address can be out of range.
    if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
        assign addr_oor = 1'b0;
    end else begin : g_part_range
        localparam logic [ADDR_W-1:0] DepthLim = ADDR_W'(DEPTH);
        assign addr_oor = (addr >= DepthLim);
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = addr_oor ? StDone : StAccess;
                end
            end
            StAccess:  state_d = (op_q == OP_WRITE) ? StDone : StCapture;
            StCapture: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and registered flags only
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        unique case (state_q)
            StIdle: ;
            StAccess: begin
                busy      = 1'b1;
                ram_read  = (op_q == OP_READ);
                ram_write = (op_q == OP_WRITE);
            end
            StCapture: busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // MAR, op and error flag are captured together on acceptance
    always_comb begin
        mar_d = mar_q;
        op_d  = op_q;
        err_d = err_q;
        if (accept) begin
            mar_d = addr;
            op_d  = wr;
            err_d = addr_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mar_q <= '0;
            op_q  <= OP_READ;
            err_q <= 1'b0;
        end else begin
            mar_q <= mar_d;
            op_q  <= op_d;
            err_q <= err_d;
        end
    end

    // MDR takes write data on acceptance (even if the address is rejected)
    // and RAM data in CAPTURE, one cycle after the read strobe.
    mdr_reg #(
        .DATA_W(DATA_W)
    ) u_mdr (
        .clk         (clk),
        .clr         (clr),
        .load_wdata_i(accept && wr),
        .load_rdata_i(state_q == StCapture),
        .wdata_i     (wdata),
        .ram_dout_i  (ram_dout),
        .q_o         (mdr)
    );

    assign rdata    = mdr;
    assign ram_din  = mdr;
    assign ram_addr = mar_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: instance 0 has DEPTH=512, instance 1 has DEPTH=256.
// Each instance is attached to its own registered-read RAM model.
module tb_mem_ctrl;

    logic        clk;
    logic        clr;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;

    logic        req_v    [2];
    logic [31:0] rdata_v  [2];
    logic        busy_v   [2];
    logic        done_v   [2];
    logic        err_v    [2];
    logic        rd_v     [2];
    logic        wrs_v    [2];
    logic [8:0]  raddr_v  [2];
    logic [31:0] rdin_v   [2];

    int nchecks = 0;
    int nerrs   = 0;

    // Reference model: memory contents, which words were written, and the
    // value the data register must hold.
    logic [31:0] mdl    [2][512];
    bit          mdl_ok [2][512];
    logic [31:0] mdr_m  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram [512];
        logic [31:0] dout_q;

        mem_ctrl #(
            .ADDR_W(9),
            .DATA_W(32),
            .DEPTH ((g == 0) ? 512 : 256)
        ) u_dut (
            .clk      (clk),
            .clr      (clr),
            .req      (req_v[g]),
            .wr       (wr),
            .addr     (addr),
            .wdata    (wdata),
            .rdata    (rdata_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .err      (err_v[g]),
            .ram_read (rd_v[g]),
            .ram_write(wrs_v[g]),
            .ram_addr (raddr_v[g]),
            .ram_din  (rdin_v[g]),
            .ram_dout (dout_q)
        );

        always @(posedge clk) begin
            if (wrs_v[g]) ram[raddr_v[g]] <= rdin_v[g];
            if (rd_v[g]) dout_q <= ram[raddr_v[g]];
        end
    end

    typedef struct {
        int          s;
        logic        w;
        logic [8:0]  a;
        logic [31:0] d;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    function automatic int depth_of(input int s);
        return (s == 0) ? 512 : 256;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on instance s; checks latency, status, strobes and rdata.
    task automatic txn(input int s, input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic exp_err, input int exp_lat, input logic [31:0] exp_rdata);
        int          n_rd, n_wr, lat, c;
        logic        got, both, addr_bad, din_bad, busy_low, err_seen;
        logic [31:0] rd_seen;
        n_rd = 0; n_wr = 0; lat = 0; c = 1;
        got = 0; both = 0; addr_bad = 0; din_bad = 0; busy_low = 0; err_seen = 0;
        rd_seen = '0;
        req_v[s] = 1'b1; wr = w; addr = a; wdata = d;
        step();
        req_v[s] = 1'b0;
        while (!got && c <= 6) begin
            if (rd_v[s]) n_rd++;
            if (wrs_v[s]) begin
                n_wr++;
                if (rdin_v[s] !== d) din_bad = 1;
            end
            if ((rd_v[s] || wrs_v[s]) && raddr_v[s] !== a) addr_bad = 1;
            if (rd_v[s] && wrs_v[s]) both = 1;
            if (!busy_v[s]) busy_low = 1;
            if (done_v[s]) begin
                got = 1; lat = c; err_seen = err_v[s]; rd_seen = rdata_v[s];
            end else begin
                step();
                c++;
            end
        end
        check("latency", lat, exp_lat);
        check("err", err_seen, exp_err);
        check("rdata", rd_seen, exp_rdata);
        check("read_strobes", n_rd, (!w && !exp_err) ? 1 : 0);
        check("write_strobes", n_wr, (w && !exp_err) ? 1 : 0);
        check("strobe_addr", addr_bad, 0);
        check("strobe_din", din_bad, 0);
        check("strobes_exclusive", both, 0);
        check("busy_during", busy_low, 0);
        step();
        check("busy_after", busy_v[s], 0);
        check("done_after", done_v[s], 0);
    endtask

    task automatic check_zero(input int s, input string tag);
        check({tag, "_busy"}, busy_v[s], 0);
        check({tag, "_done"}, done_v[s], 0);
        check({tag, "_err"}, err_v[s], 0);
        check({tag, "_ram_read"}, rd_v[s], 0);
        check({tag, "_ram_write"}, wrs_v[s], 0);
        check({tag, "_rdata"}, rdata_v[s], 0);
        check({tag, "_ram_addr"}, {23'b0, raddr_v[s]}, 0);
        check({tag, "_ram_din"}, rdin_v[s], 0);
    endtask

    initial begin
        int          next_free, done_at, n_acc, n_done, lat;
        logic        w, e;
        logic [8:0]  a;
        logic [31:0] d, pend;

        tbl[0]  = '{0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
        tbl[1]  = '{0, 1'b0, 9'h005, 32'h0,        1'b0, 3, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 9'h1FF, 32'hFFFFFFFF, 1'b0, 2, 32'hFFFFFFFF};
        tbl[3]  = '{0, 1'b0, 9'h1FF, 32'h0,        1'b0, 3, 32'hFFFFFFFF};
        tbl[4]  = '{0, 1'b1, 9'h000, 32'h12345678, 1'b0, 2, 32'h12345678};
        tbl[5]  = '{0, 1'b0, 9'h000, 32'h0,        1'b0, 3, 32'h12345678};
        tbl[6]  = '{0, 1'b0, 9'h005, 32'h0,        1'b0, 3, 32'hDEADBEEF};
        tbl[7]  = '{1, 1'b1, 9'h0FF, 32'hCAFEF00D, 1'b0, 2, 32'hCAFEF00D};
        tbl[8]  = '{1, 1'b0, 9'h100, 32'h0,        1'b1, 1, 32'hCAFEF00D};
        tbl[9]  = '{1, 1'b1, 9'h1FF, 32'h01234567, 1'b1, 1, 32'h01234567};
        tbl[10] = '{1, 1'b0, 9'h0FF, 32'h0,        1'b0, 3, 32'hCAFEF00D};

        clr = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        mdr_m[0] = '0; mdr_m[1] = '0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 512; i++) mdl_ok[s][i] = 0;

        step();
        step();
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        clr = 1'b0;
        step();

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d,
                tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_rdata);
            if (tbl[i].w && !tbl[i].exp_err) begin
                mdl[tbl[i].s][tbl[i].a]    = tbl[i].d;
                mdl_ok[tbl[i].s][tbl[i].a] = 1;
            end
            mdr_m[tbl[i].s] = tbl[i].exp_rdata;
        end

        // req held high for 10 cycles with wr alternating
        next_free = 0; done_at = -1; n_acc = 0; n_done = 0; pend = '0;
        for (int i = 0; i < 16; i++) begin
            req_v[0] = (i < 10);
            wr       = (i % 2 == 0);
            addr     = 9'h010;
            wdata    = 32'hA5A50000 + i;
            check("hold_done", done_v[0], (i == done_at) ? 1 : 0);
            check("hold_strobes", rd_v[0] & wrs_v[0], 0);
            if (i == done_at) check("hold_rdata", rdata_v[0], pend);
            if (done_v[0]) n_done++;
            if (req_v[0] && i >= next_free) begin
                lat       = wr ? 2 : 3;
                done_at   = i + lat;
                next_free = done_at + 1;
                n_acc++;
                if (wr) begin
                    mdl[0][16]    = wdata;
                    mdl_ok[0][16] = 1;
                    pend          = wdata;
                end else begin
                    pend = mdl[0][16];
                end
                mdr_m[0] = pend;
            end
            step();
        end
        req_v[0] = 1'b0;
        check("hold_one_done_per_accept", n_done, n_acc);

        // Reset during CAPTURE of a read
        req_v[0] = 1'b1; wr = 1'b0; addr = 9'h005;
        step();
        req_v[0] = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_zero(0, "clr_capture");
        mdr_m[0] = '0; mdr_m[1] = '0;
        txn(0, 1'b0, 9'h005, 32'h0, 1'b0, 3, mdl[0][5]);
        mdr_m[0] = mdl[0][5];

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            int s;
            s = n % 2;
            a = 9'($urandom_range(0, 511));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            e = (int'(a) >= depth_of(s));
            if (!w && !e && !mdl_ok[s][a]) w = 1'b1;
            if (w) mdr_m[s] = d;
            else if (!e) mdr_m[s] = mdl[s][a];
            txn(s, w, a, d, e, e ? 1 : (w ? 2 : 3), mdr_m[s]);
            if (w && !e) begin
                mdl[s][a]    = d;
                mdl_ok[s][a] = 1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
